// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, state type and lane helpers
// for the load/store controller.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  function automatic logic [4:0] byte_sh(
    input logic [1:0] lane
  );
    return {lane, 3'b000};
  endfunction

  function automatic logic [4:0] half_sh(
    input logic lane
  );
    return {lane, 4'b0000};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store-lane merge and load extract/extend.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            lane,
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] ld_word,
  output logic [DATA_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0] ld_data
);

  localparam int DW = DATA_WIDTH;

  logic [4:0]    bsh;
  logic [4:0]    hsh;
  logic [DW-1:0] bmask;
  logic [DW-1:0] hmask;
  logic [7:0]    bsel;
  logic [15:0]   hsel;

  always_comb begin
    bsh   = byte_sh(lane);
    hsh   = half_sh(lane[1]);
    bmask = DW'(8'hFF) << bsh;
    hmask = DW'(16'hFFFF) << hsh;
    bsel  = 8'(ld_word >> bsh);
    hsel  = 16'(ld_word >> hsh);
  end

  // Clear the lane first so old bits are replaced, not ORed.
  always_comb begin
    merged = wdata;
    unique case (1'b1)
      (funct3 == F3_B):
        merged = (old_word & ~bmask)
               | ((wdata & DW'(8'hFF)) << bsh);
      (funct3 == F3_H):
        merged = (old_word & ~hmask)
               | ((wdata & DW'(16'hFFFF)) << hsh);
      default:
        merged = wdata;
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    unique case (1'b1)
      (funct3 == F3_B):
        ld_data = {{(DW-8){bsel[7]}}, bsel};
      (funct3 == F3_BU):
        ld_data = {{(DW-8){1'b0}}, bsel};
      (funct3 == F3_H):
        ld_data = {{(DW-16){hsel[15]}}, hsel};
      (funct3 == F3_HU):
        ld_data = {{(DW-16){1'b0}}, hsel};
      default:
        ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store FSM with read-modify-write
// for sub-word stores against a word-organised memory.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  state_t                state;
  state_t                nxt;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  f3_ok;
  logic                  mis;
  logic                  bad;

  lsu_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .funct3  (f3_q),
    .lane    (addr_q[1:0]),
    .old_word(word_q),
    .wdata   (wdata_q),
    .ld_word (mem_rd_data),
    .merged  (merged),
    .ld_data (ld_data)
  );

  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    f3_ok = req_funct3 inside
      {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    mis = ((req_funct3 == F3_H ||
            req_funct3 == F3_HU) && req_addr[0])
       || (req_funct3 == F3_W &&
           req_addr[1:0] != 2'b00);
    bad = !f3_ok || mis
       || (req_we && req_funct3[2]);
  end

  always_comb begin
    nxt         = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          nxt = bad ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        mem_addr = word_addr;
        nxt      = we_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_wr_en   = !reset;
        mem_addr    = word_addr;
        mem_wr_data = merged;
        nxt         = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        nxt        = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= bad;
        rdata_q <= '0;
      end
      if (state == S_ACCESS) begin
        word_q <= mem_rd_data;
        if (!we_q)
          rdata_q <= ld_data;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed scoreboard bench for lsu_ctrl
// with a 64-word memory model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  always #5 clk = ~clk;

  lsu_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  logic [31:0] mem [64] = '{default: 32'h0};
  assign mem_rd_data = mem[mem_addr[7:2]];
  always @(posedge clk)
    if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wr_data;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] wq[$];
  int          acc_q[$];
  int          acc_n = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, want);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: inputs change only at posedge+1, so negedge is stable.
  always @(negedge clk) begin
    if (!reset && req_valid && req_ready) begin
      acc_q.push_back(cyc + 1);
      acc_n++;
    end
    if (mem_wr_en) begin
      if (wq.size() == 0) flag("unexpected write");
      else begin
        logic [63:0] w;
        w = wq.pop_front();
        chk("wr_addr", mem_addr, w[63:32]);
        chk("wr_data", mem_wr_data, w[31:0]);
      end
    end
    if (resp_valid) begin
      if (rv_prev) flag("resp_valid longer than 1 cycle");
      if (exp_q.size() == 0) flag("unexpected resp");
      else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        chk("rdata", resp_rdata, e.rdata);
        chk("err", {31'b0, resp_err}, {31'b0, e.err});
        if (acc_q.size() == 0) flag("resp without accept");
        else begin
          a = acc_q.pop_front();
          chk("latency", cyc - a + 1, {24'b0, e.lat});
          chk("outstanding", acc_q.size(), 0);
        end
      end
    end
    rv_prev <= resp_valid;
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) flag("ready timeout");
  endtask

  task automatic wait_resp();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      flag("resp timeout");
      exp_q.delete();
    end
  endtask

  task automatic drive(input logic        we,
                       input logic [2:0]  f3,
                       input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic xfer(input logic        we,
                      input logic [2:0]  f3,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input logic [31:0] rd,
                      input logic        err,
                      input logic [31:0] wword);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    e.lat   = err ? 8'd1 : (we ? 8'd3 : 8'd2);
    wait_ready();
    exp_q.push_back(e);
    if (we && !err)
      wq.push_back({addr & 32'hFFFF_FFFC, wword});
    drive(we, f3, addr, wd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", {31'b0, req_ready}, 1);
    chk("rst resp_valid", {31'b0, resp_valid}, 0);
    chk("rst mem_wr_en", {31'b0, mem_wr_en}, 0);
    chk("rst rdata", resp_rdata, 0);
    chk("rst err", {31'b0, resp_err}, 0);
    chk("rst mem_addr", mem_addr, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    xfer(1, 3'b010, 32'h10, 32'hDEADBEEF,
         0, 0, 32'hDEADBEEF);
    chk("mem4 sw", mem[4], 32'hDEADBEEF);
    xfer(0, 3'b010, 32'h10, 0,
         32'hDEADBEEF, 0, 0);

    xfer(1, 3'b000, 32'h11, 32'h123456AA,
         0, 0, 32'hDEADAAEF);
    chk("mem4 sb", mem[4], 32'hDEADAAEF);
    xfer(0, 3'b000, 32'h11, 0,
         32'hFFFFFFAA, 0, 0);
    xfer(0, 3'b100, 32'h11, 0,
         32'h000000AA, 0, 0);

    xfer(1, 3'b001, 32'h12, 32'h00001234,
         0, 0, 32'h1234AAEF);
    chk("mem4 sh", mem[4], 32'h1234AAEF);
    xfer(0, 3'b001, 32'h12, 0,
         32'h00001234, 0, 0);
    xfer(0, 3'b101, 32'h10, 0,
         32'h0000AAEF, 0, 0);
    xfer(0, 3'b001, 32'h10, 0,
         32'hFFFFAAEF, 0, 0);
    xfer(0, 3'b010, 32'h110, 0,
         32'h1234AAEF, 0, 0);

    xfer(0, 3'b001, 32'h13, 0, 0, 1, 0);
    xfer(1, 3'b010, 32'h12, 32'hFFFF, 0, 1, 0);
    xfer(1, 3'b100, 32'h10, 32'hFF, 0, 1, 0);
    xfer(0, 3'b011, 32'h10, 0, 0, 1, 0);
    chk("mem4 after errs", mem[4], 32'h1234AAEF);

    wait_ready();
    drive(1, 3'b010, 32'h20, 32'h55);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst-wr mem_addr", mem_addr, 32'h20);
    reset = 1'b1;
    #1;
    chk("rst-wr wr_en", {31'b0, mem_wr_en}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    acc_q.delete();
    chk("rst-wr ready", {31'b0, req_ready}, 1);
    chk("rst-wr resp", {31'b0, resp_valid}, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("mem8 no write", mem[8], 0);

    begin
      exp_t e;
      int   base;
      int   n;
      e.rdata = 0;
      e.err   = 0;
      e.lat   = 8'd3;
      wait_ready();
      base = acc_n;
      exp_q.push_back(e);
      exp_q.push_back(e);
      wq.push_back({32'h30, 32'hCAFEF00D});
      wq.push_back({32'h34, 32'h11111111});
      drive(1, 3'b010, 32'h30, 32'hCAFEF00D);
      @(posedge clk); #1;
      req_addr  = 32'h34;
      req_wdata = 32'h11111111;
      n = 0;
      while (acc_n < base + 2 && n < 30) begin
        @(posedge clk); #1;
        n++;
      end
      req_valid = 1'b0;
      chk("held accepts", acc_n - base, 2);
      wait_resp();
    end
    chk("mem12", mem[12], 32'hCAFEF00D);
    chk("mem13", mem[13], 32'h11111111);

    repeat (3) @(posedge clk);
    #1;
    chk("writes left", wq.size(), 0);
    chk("resps left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
